mram_ctrl: RTL and testbench

Request-side controller for the 16-bit MRAM array model. It accepts single-word read/write requests on a valid/ready host port and sequences the MRAM pins: chip enable, active-low write enable, and active-low lower/upper byte-lane enables. It drives the write bus with an output enable, captures read data one cycle after the access, and returns it on a response strobe. It sits directly upstream of the MRAM; tristating of the shared data bus is done in a separate pad wrapper.

---
 rtl/mram_ctrl_pkg.sv | 29 ++
 rtl/mram_dq_iobuf.sv | 27 ++
 rtl/mram_ctrl.sv | 131 +++++++++++++
 tb/tb_mram_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mram_ctrl_pkg
// Shared types and constants for the MRAM request-side controller and its
// data-pad wrapper.
//   state_t     : controller FSM states (IDLE, ACCESS, CAPTURE, TURN)
//   DATA_WIDTH  : MRAM word width (two byte lanes)
//   LANE_LO/HI  : byte-lane indices into req_be / lane enables
//   lane_mask() : expands a 2-bit byte-enable into a 16-bit data mask
// ---------------------------------------------------------------------------
package mram_ctrl_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int LANE_WIDTH = 8;
  localparam int LANE_LO    = 0;
  localparam int LANE_HI    = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    TURN    = 2'd3
  } state_t;

  // Disabled lanes are forced to zero on the read path.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] be);
    return {{LANE_WIDTH{be[LANE_HI]}}, {LANE_WIDTH{be[LANE_LO]}}};
  endfunction

endpackage

// File: rtl/mram_dq_iobuf.sv
// ---------------------------------------------------------------------------
// mram_dq_iobuf
// Pad wrapper that turns the controller's split data bus into the MRAM's
// bidirectional byte-lane pins. It is instantiated next to mram_ctrl at the
// level that owns the pins, never inside the controller.
// Ports:
//   dq_out  in    16  write data from mram_ctrl (mem_dq_out)
//   dq_oe   in     1  output enable from mram_ctrl (mem_dq_oe)
//   dq_in   out   16  bus value returned to mram_ctrl (mem_dq_in)
//   dqu     inout  8  upper byte-lane pins
//   dql     inout  8  lower byte-lane pins
// ---------------------------------------------------------------------------
module mram_dq_iobuf
  import mram_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] dq_out,
  input  logic                  dq_oe,
  output logic [DATA_WIDTH-1:0] dq_in,
  inout  wire  [LANE_WIDTH-1:0] dqu,
  inout  wire  [LANE_WIDTH-1:0] dql
);

  assign dqu   = dq_oe ? dq_out[DATA_WIDTH-1:LANE_WIDTH] : {LANE_WIDTH{1'bz}};
  assign dql   = dq_oe ? dq_out[LANE_WIDTH-1:0]          : {LANE_WIDTH{1'bz}};
  assign dq_in = {dqu, dql};

endmodule

// File: rtl/mram_ctrl.sv
// ---------------------------------------------------------------------------
// mram_ctrl
// Request-side controller for a 16-bit MRAM. Accepts single-word read/write
// requests on a valid/ready port, runs one ACCESS cycle on the MRAM pins,
// captures read data one cycle later and returns it on a one-cycle strobe.
// Build option:
//   MRAM_CTRL_WR_TURNAROUND_EN : when defined, every write is followed by a
//                                TURN cycle so the bus is idle for one cycle
//                                before the next access.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   req_valid/req_ready      host handshake
//   req_write/addr/wdata/be  request fields (be active high, [1]=upper)
//   resp_valid/resp_rdata    read-data strobe and data (disabled lanes = 0)
//   mem_enable               MRAM chip enable, active high
//   mem_write_en             0 = write, 1 = read
//   mem_lb_enable/ub_enable  byte-lane enables, active low
//   mem_addr                 MRAM word address
//   mem_dq_out/mem_dq_oe     write data and pad output enable
//   mem_dq_in                bus value from the pad wrapper
// ---------------------------------------------------------------------------
module mram_ctrl
  import mram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_be,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_enable,
  output logic                  mem_write_en,
  output logic                  mem_lb_enable,
  output logic                  mem_ub_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dq_out,
  output logic                  mem_dq_oe,
  input  logic [DATA_WIDTH-1:0] mem_dq_in
);

  state_t     state;
  logic       write_q;
  logic [1:0] be_q;

  // Ready is a pure decode of the registered state, held low during reset.
  assign req_ready = (state == IDLE) && !rst;

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments here would let later
  // statements see half-updated state and break simulation/synthesis match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      be_q          <= 2'b00;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_enable    <= 1'b0;
      mem_write_en  <= 1'b1;
      mem_lb_enable <= 1'b1;
      mem_ub_enable <= 1'b1;
      mem_addr      <= '0;
      mem_dq_out    <= '0;
      mem_dq_oe     <= 1'b0;
    end else begin
      // Pin defaults: every cycle that is not an ACCESS cycle leaves the
      // MRAM deselected and the bus released.
      resp_valid    <= 1'b0;
      mem_enable    <= 1'b0;
      mem_write_en  <= 1'b1;
      mem_lb_enable <= 1'b1;
      mem_ub_enable <= 1'b1;
      mem_dq_oe     <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q       <= req_write;
            be_q          <= req_be;
            // Pins are registered, so the ACCESS cycle's values are loaded
            // on the accepting edge itself.
            mem_enable    <= 1'b1;
            mem_addr      <= req_addr;
            mem_lb_enable <= ~req_be[LANE_LO];
            mem_ub_enable <= ~req_be[LANE_HI];
            mem_write_en  <= ~req_write;
            if (req_write) begin
              mem_dq_oe  <= 1'b1;
              mem_dq_out <= req_wdata;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (write_q) begin
`ifdef MRAM_CTRL_WR_TURNAROUND_EN
            state <= TURN;
`else
            state <= IDLE;
`endif
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          // The MRAM has been driving the bus since the end of ACCESS.
          resp_rdata <= mem_dq_in & lane_mask(be_q);
          resp_valid <= 1'b1;
          state      <= IDLE;
        end

        TURN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mram_ctrl
// Self-checking bench for mram_ctrl. The controller drives a simple MRAM
// model through mram_dq_iobuf; expected read data comes from a separate
// word-array reference updated from the request stream alone.
// ---------------------------------------------------------------------------
module tb_mram_ctrl;
  import mram_ctrl_pkg::*;

  localparam int AW = 20;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [15:0]     req_wdata;
  logic [1:0]      req_be;
  logic            resp_valid;
  logic [15:0]     resp_rdata;
  logic            mem_enable;
  logic            mem_write_en;
  logic            mem_lb_enable;
  logic            mem_ub_enable;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_dq_out;
  logic            mem_dq_oe;
  logic [15:0]     mem_dq_in;
  wire  [7:0]      dqu;
  wire  [7:0]      dql;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_last_rdata;

  mram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .mem_enable    (mem_enable),
    .mem_write_en  (mem_write_en),
    .mem_lb_enable (mem_lb_enable),
    .mem_ub_enable (mem_ub_enable),
    .mem_addr      (mem_addr),
    .mem_dq_out    (mem_dq_out),
    .mem_dq_oe     (mem_dq_oe),
    .mem_dq_in     (mem_dq_in)
  );

  mram_dq_iobuf u_pad (
    .dq_out (mem_dq_out),
    .dq_oe  (mem_dq_oe),
    .dq_in  (mem_dq_in),
    .dqu    (dqu),
    .dql    (dql)
  );

  // ---------------- MRAM array model (environment, not the reference) -----
  logic [15:0] mram [0:255];
  logic        mram_drive;
  logic        mram_lb_drv;
  logic        mram_ub_drv;
  logic [15:0] mram_dout;

  assign dqu = (mram_drive && mram_ub_drv) ? mram_dout[15:8] : 8'bz;
  assign dql = (mram_drive && mram_lb_drv) ? mram_dout[7:0]  : 8'bz;

  always @(posedge clk) begin
    mram_drive <= 1'b0;
    if (mem_enable) begin
      if (!mem_write_en) begin
        if (!mem_lb_enable) mram[mem_addr[7:0]][7:0]  <= dql;
        if (!mem_ub_enable) mram[mem_addr[7:0]][15:8] <= dqu;
      end else begin
        mram_drive  <= 1'b1;
        mram_lb_drv <= !mem_lb_enable;
        mram_ub_drv <= !mem_ub_enable;
        mram_dout   <= mram[mem_addr[7:0]];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers -----------------------------------------------
  // Presents a request and returns the cycle count just after the edge at
  // which it was accepted. Leaves req_valid high; callers drop it.
  task automatic present(input logic w, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         output int acc);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    int acc;
    present(1'b1, a, d, be, acc);
    req_valid = 1'b0;
    checks++;
    if ({mem_enable, mem_write_en, mem_lb_enable, mem_ub_enable, mem_dq_oe} !==
        {1'b1, 1'b0, ~be[0], ~be[1], 1'b1} || mem_addr !== a || mem_dq_out !== d) begin
      errors++;
      $display("FAIL wr_access_pins: en=%b we=%b lb=%b ub=%b oe=%b addr=%h dq=%h required 1 0 %b %b 1 %h %h",
               mem_enable, mem_write_en, mem_lb_enable, mem_ub_enable, mem_dq_oe,
               mem_addr, mem_dq_out, ~be[0], ~be[1], a, d);
    end
    checks++;
    if (resp_rdata !== exp_last_rdata) begin
      errors++;
      $display("FAIL rdata_hold: got %h required %h", resp_rdata, exp_last_rdata);
    end
    if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
    if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] be);
    int          acc;
    int          lat;
    logic [15:0] exp;
    exp = ref_mem[a[7:0]] & {{8{be[1]}}, {8{be[0]}}};
    present(1'b0, a, 16'h0000, be, acc);
    req_valid = 1'b0;
    checks++;
    if ({mem_enable, mem_write_en, mem_lb_enable, mem_ub_enable, mem_dq_oe} !==
        {1'b1, 1'b1, ~be[0], ~be[1], 1'b0} || mem_addr !== a) begin
      errors++;
      $display("FAIL rd_access_pins: en=%b we=%b lb=%b ub=%b oe=%b addr=%h required 1 1 %b %b 0 %h",
               mem_enable, mem_write_en, mem_lb_enable, mem_ub_enable, mem_dq_oe,
               mem_addr, ~be[0], ~be[1], a);
    end
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL rd_latency: resp_valid after %0d edges required 2", lat);
    end
    checks++;
    if (resp_rdata !== exp) begin
      errors++;
      $display("FAIL rd_data addr=%h be=%b: got %h required %h", a, be, resp_rdata, exp);
    end
    exp_last_rdata = exp;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_strobe_width: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({req_ready, resp_valid, mem_enable, mem_write_en, mem_lb_enable,
         mem_ub_enable, mem_dq_oe} !== 7'b0001110 ||
        resp_rdata !== 16'h0000 || mem_addr !== '0 || mem_dq_out !== 16'h0000) begin
      errors++;
      $display("FAIL %s: rdy=%b rv=%b en=%b we=%b lb=%b ub=%b oe=%b rd=%h addr=%h dq=%h required 0 0 0 1 1 1 0 0 0 0",
               tag, req_ready, resp_valid, mem_enable, mem_write_en, mem_lb_enable,
               mem_ub_enable, mem_dq_oe, resp_rdata, mem_addr, mem_dq_out);
    end
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    #1;
    check_reset_outputs("reset_values");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    do_write(20'h00010, 16'hA55A, 2'b11);
    do_read(20'h00010, 2'b11);
    checks++;
    if (resp_rdata !== 16'hA55A) begin
      errors++;
      $display("FAIL full_word_readback: got %h required a55a", resp_rdata);
    end
  endtask

  task automatic test_partial_write();
    do_write(20'h00020, 16'h1234, 2'b01);
    do_read(20'h00020, 2'b11);
    checks++;
    if (resp_rdata !== 16'h0034) begin
      errors++;
      $display("FAIL lower_lane_write: got %h required 0034", resp_rdata);
    end
  endtask

  task automatic test_read_lane();
    do_read(20'h00010, 2'b10);
    checks++;
    if (resp_rdata !== 16'hA500) begin
      errors++;
      $display("FAIL upper_lane_read: got %h required a500", resp_rdata);
    end
  endtask

  task automatic test_be_zero();
    do_write(20'h00010, 16'hFFFF, 2'b00);
    do_read(20'h00010, 2'b11);
    checks++;
    if (resp_rdata !== 16'hA55A) begin
      errors++;
      $display("FAIL be_zero_write: got %h required a55a", resp_rdata);
    end
    do_read(20'h00010, 2'b00);
    checks++;
    if (resp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL be_zero_read: got %h required 0000", resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int prev;
    int exp_gap;
`ifdef MRAM_CTRL_WR_TURNAROUND_EN
    exp_gap = 3;
`else
    exp_gap = 2;
`endif
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      present(1'b1, 20'(32'h40 + k), d, 2'b11, acc);
      ref_mem[8'(32'h40 + k)] = d;
      if (prev >= 0) begin
        checks++;
        if (acc - prev != exp_gap) begin
          errors++;
          $display("FAIL b2b_spacing: %0d cycles required %0d", acc - prev, exp_gap);
        end
      end
      prev = acc;
      // One edge after the accept the bus must already be released.
      @(posedge clk); #1;
      checks++;
      if (mem_dq_oe !== 1'b0 || mem_enable !== 1'b0) begin
        errors++;
        $display("FAIL post_write_idle: oe=%b en=%b required 0 0", mem_dq_oe, mem_enable);
      end
    end
    req_valid = 1'b0;
    do_read(20'h00042, 2'b11);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [1:0]    be;
      a  = AW'($urandom_range(0, 31));
      be = 2'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom), be);
      else                           do_read(a, be);
    end
  endtask

  task automatic test_reset_mid_read();
    int acc;
    present(1'b0, 20'h00010, 16'h0000, 2'b11, acc);
    req_valid = 1'b0;
    // Now in the ACCESS cycle of the read.
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_read");
    @(negedge clk);
    rst = 1'b0;
    exp_last_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL dropped_read_resp: resp_valid=%b cycle %0d required 0", resp_valid, i);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset: got %b required 1", req_ready);
    end
    // Controller must still work normally afterwards.
    do_read(20'h00010, 2'b11);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_be         = 2'b00;
    mram_drive     = 1'b0;
    mram_lb_drv    = 1'b0;
    mram_ub_drv    = 1'b0;
    mram_dout      = '0;
    exp_last_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mram[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    test_reset();
    test_write_read();
    test_partial_write();
    test_read_lane();
    test_be_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
